// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and width helpers for the shared-bus round-robin arbiter.
package shared_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn  = 2'd1,
      StTurn = 2'd2
   } state_e;

   // Counter width that stays at least one bit for a modulus of 1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DefNumReq     = 4;
   localparam int unsigned DefMaxHold    = 8;
   localparam int unsigned DefTurnCycles = 1;

   localparam int unsigned OwnerW = cnt_width(DefNumReq);
   localparam int unsigned HoldW  = cnt_width(DefMaxHold);
   localparam int unsigned TurnW  = cnt_width(DefTurnCycles);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] k;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      k      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!valid && req[k]) begin
            valid     = 1'b1;
            winner[k] = 1'b1;
            idx       = k;
         end
      end
   end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner sequencing for a shared tri-state bus with turnaround gaps
// and hold-time pre-emption. Drives the buffer enables directly.
module shared_bus_arbiter
   import shared_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ     = DefNumReq,
   parameter int unsigned MAX_HOLD    = DefMaxHold,
   parameter int unsigned TURN_CYCLES = DefTurnCycles
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         drive_en,
   output logic                       bus_busy,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       preempted
);

   localparam int unsigned OwW = $clog2(NUM_REQ);
   localparam int unsigned HW  = cnt_width(MAX_HOLD);
   localparam int unsigned TW  = cnt_width(TURN_CYCLES);

   localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0] TurnLast = TW'(TURN_CYCLES - 1);

   state_e             state_q;
   logic [HW-1:0]      hold_q;
   logic [TW-1:0]      turn_q;
   logic [OwW-1:0]     ptr_q;

   logic               pick_valid;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [OwW-1:0]     pick_idx;
   logic [OwW-1:0]     next_ptr;
   logic               others;
   logic               start_own;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OwW)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr_q),
      .valid  (pick_valid),
      .winner (pick_onehot),
      .idx    (pick_idx)
   );

   assign next_ptr  = OwW'((int'(pick_idx) + 1) % NUM_REQ);
   assign others    = |(req & ~grant);
   // The last turnaround edge arbitrates exactly like IDLE, with no extra idle cycle.
   assign start_own = pick_valid &&
                      ((state_q == StIdle) || ((state_q == StTurn) && (turn_q == TurnLast)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         grant     <= '0;
         drive_en  <= '0;
         bus_busy  <= 1'b0;
         owner     <= '0;
         preempted <= 1'b0;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
      end else begin
         preempted <= 1'b0;
         if (start_own) begin
            state_q  <= StOwn;
            grant    <= pick_onehot;
            drive_en <= pick_onehot;
            owner    <= pick_idx;
            bus_busy <= 1'b1;
            hold_q   <= '0;
            ptr_q    <= next_ptr;
         end else begin
            unique case (state_q)
               StIdle: ;
               StOwn: begin
                  if (hold_q != HoldLast) hold_q <= hold_q + 1'b1;
                  if (!req[owner] || ((hold_q == HoldLast) && others)) begin
                     state_q   <= StTurn;
                     grant     <= '0;
                     drive_en  <= '0;
                     turn_q    <= '0;
                     preempted <= req[owner];
                  end
               end
               StTurn: begin
                  if (turn_q == TurnLast) begin
                     state_q  <= StIdle;
                     bus_busy <= 1'b0;
                  end else begin
                     turn_q <= turn_q + 1'b1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
